// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed byte stream into instruction memory and holds the CPU in reset until done
// Ports: clk, rst (async, active-low); start pulse begins a load; in_valid/in_data/in_ready byte handshake;
// im_we/im_addr/im_wdata IM write port; cpu_rst active-high CPU reset; done/error status levels.
// Frame: CNT_HI CNT_LO, 4*N payload bytes (big-endian words), then an XOR checksum byte.
// Macro BOOT_CSUM_EN enables the checksum byte and its check; undefined, the frame ends after the payload.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_WORD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
`ifdef BOOT_CSUM_EN
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif
  // Largest word count that still fits between BASE_WORD and the top of IM
  localparam logic [31:0] CAP = 32'((1 << ADDR_W) - BASE_WORD);
  state_t      state, nxt;
  logic [7:0]  cnt_hi;
  logic [15:0] n, wcnt, cnt;
  logic [1:0]  lane;
  logic [23:0] asm_q;
  logic        acc, oversize, last_byte;
`ifdef BOOT_CSUM_EN
  logic [7:0]  x;
`endif
  assign acc       = in_valid && in_ready;
  assign cnt       = {cnt_hi, in_data};
  assign oversize  = {16'd0, cnt} > CAP;
  assign last_byte = lane == 2'd3 && wcnt == n - 16'd1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? HDR0 : state;
      HDR0:            nxt = acc ? HDR1 : HDR0;
      HDR1:            nxt = !acc ? HDR1 : oversize ? ERR : cnt == 16'd0 ? FIN : DATA;
      DATA:            nxt = acc && last_byte ? FIN : DATA;
`ifdef BOOT_CSUM_EN
      CSUM:            nxt = !acc ? CSUM : in_data == x ? DONE : ERR;
`endif
      default:         nxt = IDLE;
    endcase
  end
  // Status outputs are registered from the next state so they change together with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      cnt_hi   <= '0;
      n        <= '0;
      wcnt     <= '0;
      lane     <= '0;
      asm_q    <= '0;
`ifdef BOOT_CSUM_EN
      x        <= '0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= nxt inside {HDR0, HDR1, DATA, CSUM};
      cpu_rst  <= nxt != DONE;
      done     <= nxt == DONE;
      error    <= nxt == ERR;
      im_we    <= 1'b0;
      if (state inside {IDLE, DONE, ERR} && start) begin
        wcnt <= '0;
        lane <= '0;
`ifdef BOOT_CSUM_EN
        x    <= '0;
`endif
      end
      if (acc && state == HDR0) cnt_hi <= in_data;
      if (acc && state == HDR1) n <= cnt;
      if (acc && state == DATA) begin
        lane  <= lane + 2'd1;
        asm_q <= {asm_q[15:0], in_data};
`ifdef BOOT_CSUM_EN
        x     <= x ^ in_data;
`endif
        if (lane == 2'd3) begin
          im_we    <= 1'b1;
          im_wdata <= {asm_q, in_data};
          im_addr  <= ADDR_W'(BASE_WORD) + wcnt[ADDR_W-1:0];
          wcnt     <= wcnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: frame-level model and per-cycle checker for two loader instances
module tb_imem_boot_loader;
`ifdef BOOT_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 0, rst = 0, start = 0, in_valid = 0, sel = 0;
  logic [7:0] in_data = 0;
  logic rdy0, we0, cr0, dn0, er0, rdy1, we1, cr1, dn1, er1, rdy;
  logic [9:0] a0;
  logic [3:0] a1;
  logic [31:0] w0, w1;
  always #5 clk = ~clk;
  assign rdy = sel ? rdy1 : rdy0;
  imem_boot_loader dut0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(rdy0), .im_we(we0), .im_addr(a0), .im_wdata(w0), .cpu_rst(cr0), .done(dn0), .error(er0));
  imem_boot_loader #(.ADDR_W(4), .BASE_WORD(2)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel), .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(rdy1), .im_we(we1), .im_addr(a1), .im_wdata(w1), .cpu_rst(cr1), .done(dn1), .error(er1));
  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t q0[$], q1[$];
  bit exp_load[2], exp_done[2], exp_err[2];
  int checks = 0, failures = 0;
  int wr_cnt[2];
  logic [31:0] last_addr[2], last_data[2];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_dut(input int d, input logic r, input logic we, input logic cr, input logic dn,
                         input logic er, input logic [31:0] a, input logic [31:0] w);
    wr_t e;
    chk($sformatf("in_ready%0d", d), 32'(r), 32'(exp_load[d]));
    chk($sformatf("done%0d", d), 32'(dn), 32'(exp_done[d]));
    chk($sformatf("error%0d", d), 32'(er), 32'(exp_err[d]));
    chk($sformatf("cpu_rst%0d", d), 32'(cr), 32'(!exp_done[d]));
    if (we) begin
      wr_cnt[d]++;
      last_addr[d] = a;
      last_data[d] = w;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write%0d: got addr %h data %h expected no write", d, a, w);
      end else begin
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("im_addr%0d", d), a, 32'(e.addr));
        chk($sformatf("im_wdata%0d", d), w, e.data);
      end
    end
  endtask
  always @(negedge clk) begin
    chk_dut(0, rdy0, we0, cr0, dn0, er0, 32'(a0), w0);
    chk_dut(1, rdy1, we1, cr1, dn1, er1, 32'(a1), w1);
  end
  function automatic logic [7:0] xor_payload(input logic [7:0] f[$]);
    logic [7:0] x = 0;
    for (int i = 2; i < 2 + 4 * int'({f[0], f[1]}); i++) x ^= f[i];
    return x;
  endfunction
  task automatic send(input logic [7:0] b, input bit gaps, output bit ok);
    in_valid = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    in_valid = 1;
    in_data  = b;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = rdy;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
  endtask
  // Expected writes and final status are derived from the whole frame before it is streamed
  task automatic frame(input int d, input logic [7:0] f[$], input int nsend, input bit gaps);
    int n, cap, base, term;
    bit res_err, ok;
    wr_t e;
    sel = d[0];
    n = int'({f[0], f[1]});
    cap = d ? 14 : 1024;
    base = d ? 2 : 0;
    res_err = 0;
    if (n > cap) begin
      term = 1;
      res_err = 1;
    end else begin
      for (int k = 0; k < n; k++) begin
        e.addr = (base + k) % (d ? 16 : 1024);
        e.data = {f[2+4*k], f[3+4*k], f[4+4*k], f[5+4*k]};
        if (5 + 4 * k < nsend) begin
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
      term = 1 + 4 * n + CS;
      if (CS == 1) res_err = f[term] != xor_payload(f);
    end
    @(posedge clk);
    #1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    exp_load[d] = 1;
    exp_done[d] = 0;
    exp_err[d] = 0;
    for (int i = 0; i < nsend && i <= term; i++) begin
      send(f[i], gaps, ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout: got no in_ready within 100 cycles at byte %0d required accept", i);
        break;
      end
      if (i == term) begin
        exp_load[d] = 0;
        exp_done[d] = !res_err;
        exp_err[d] = res_err;
      end
    end
  endtask
  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
  endtask
  initial begin
    logic [7:0] good[$], bad[$], over[$], zero[$];
    int base_cnt;
    good = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h50};
    bad = good;
    if (CS == 1) begin
      good.push_back(8'hD9);
      bad.push_back(8'hD8);
    end
    over = {8'h00, 8'h0F};
    zero = {8'h00, 8'h00};
    if (CS == 1) zero.push_back(8'h00);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpu_rst", 32'(cr0), 1);
    chk("reset_in_ready", 32'(rdy0), 0);
    chk("reset_done", 32'(dn0), 0);
    chk("reset_error", 32'(er0), 0);
    rst = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_write", wr_cnt[0] + wr_cnt[1], 0);
    chk("csum_model", 32'(xor_payload(good)), 32'h0000_00D9);
    frame(0, good, 99, 0);
    drain();
    chk("b2b_writes", wr_cnt[0], 2);
    chk("b2b_last_data", last_data[0], 32'hAC08_0050);
    chk("b2b_last_addr", last_addr[0], 1);
    chk("b2b_done", 32'(dn0), 1);
    chk("b2b_cpu_rst", 32'(cr0), 0);
    if (CS == 1) begin
      frame(0, bad, 99, 0);
      drain();
      chk("badcs_error", 32'(er0), 1);
      chk("badcs_done", 32'(dn0), 0);
      chk("badcs_cpu_rst", 32'(cr0), 1);
    end
    frame(0, good, 99, 0);
    drain();
    chk("reload_done", 32'(dn0), 1);
    frame(1, over, 99, 0);
    drain();
    chk("over_error", 32'(er1), 1);
    chk("over_no_write", wr_cnt[1], 0);
    frame(1, good, 99, 0);
    drain();
    chk("base_last_addr", last_addr[1], 3);
    chk("base_done", 32'(dn1), 1);
    base_cnt = wr_cnt[0];
    frame(0, good, 99, 1);
    drain();
    chk("gaps_writes", wr_cnt[0] - base_cnt, 2);
    chk("gaps_done", 32'(dn0), 1);
    base_cnt = wr_cnt[0];
    frame(0, good, 7, 1);
    rst = 0;
    q0.delete();
    for (int d = 0; d < 2; d++) begin
      exp_load[d] = 0;
      exp_done[d] = 0;
      exp_err[d] = 0;
    end
    #1;
    chk("abort_in_ready", 32'(rdy0), 0);
    chk("abort_cpu_rst", 32'(cr0), 1);
    chk("abort_we", 32'(we0), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_writes", wr_cnt[0] - base_cnt, 1);
    base_cnt = wr_cnt[0];
    frame(0, zero, 99, 0);
    drain();
    chk("zero_done", 32'(dn0), 1);
    chk("zero_no_write", wr_cnt[0] - base_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 expected finish");
    $fatal(1);
  end
endmodule
